// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory responder: access size encoding, FSM states
// and the word width in bytes.
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request bus between the processor core (master) and the data
// memory responder (slave).
interface dmem_responder_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              req;
  logic              we;
  mem_size_t         size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [2:0]        wait_cfg;
  logic              ack;
  logic [31:0]       rdata;
  logic              busy;
  logic              err;

  modport master (
    output req, we, size, addr, wdata, wait_cfg,
    input  ack, rdata, busy, err
  );

  modport slave (
    input  req, we, size, addr, wdata, wait_cfg,
    output ack, rdata, busy, err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered
// read address (read data follows the cycle after the enabled access).
module dmem_array #(
  parameter int DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_en,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [IDX_W-1:0] r_raddr;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_raddr <= i_addr;
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[r_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one byte/half/word access at a time over req/ack,
// with programmable wait states. Define DMEM_ALIGN_CHECK_EN to flag misaligned
// half/word accesses as errors instead of ignoring the low address bits.
//
// state  | meaning
// IDLE   | waiting for req; request fields latched on accept
// WAIT   | counting down the latched wait states
// ACCESS | RAM read/write issued
// RESP   | one-cycle ack with rdata/err
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int WAIT_MAX = 7
) (
  input logic             ref_clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [ADDR_W-1:0] RANGE_LIMIT = ADDR_W'(DEPTH * WORD_BYTES);

  dmem_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  mem_size_t         r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic [CNT_W-1:0]  w_wait_sat;
  logic              w_size_bad;
  logic              w_oor;
  logic              w_misalign;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_load;
  logic              w_ram_en;
  logic [3:0]        w_ram_be;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [31:0]       w_ram_q;
  logic              w_ack;

  always_comb begin
    if (32'(bus.wait_cfg) > 32'(WAIT_MAX)) w_wait_sat = CNT_W'(WAIT_MAX);
    else                                   w_wait_sat = CNT_W'(bus.wait_cfg);
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req) begin
            if (w_wait_sat != '0) begin
              r_state <= WAIT;
              r_cnt   <= w_wait_sat;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ACCESS;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ACCESS: r_state <= RESP;
        RESP:   r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && bus.req) begin
      r_we    <= bus.we;
      r_size  <= bus.size;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
    end
  end

  assign w_size_bad = (r_size == SZ_RSVD);
  assign w_oor      = (r_addr >= RANGE_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = ((r_size == SZ_HALF) && r_addr[0]) ||
                      ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  assign w_err = w_size_bad | w_oor | w_misalign;

  // Replicate store data onto every lane; the byte enables pick the real ones.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_be     = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_load = '0;
    case (r_size)
      SZ_BYTE: begin
        case (r_addr[1:0])
          2'd0:    w_load = {24'h0, w_ram_q[7:0]};
          2'd1:    w_load = {24'h0, w_ram_q[15:8]};
          2'd2:    w_load = {24'h0, w_ram_q[23:16]};
          default: w_load = {24'h0, w_ram_q[31:24]};
        endcase
      end
      SZ_HALF: w_load = {16'h0, (r_addr[1] ? w_ram_q[31:16] : w_ram_q[15:0])};
      SZ_WORD: w_load = w_ram_q;
      default: ;
    endcase
  end

  // A reset landing on the ACCESS edge must still suppress the write.
  assign w_ram_en  = (r_state == ACCESS) && reset;
  assign w_ram_be  = (w_ram_en && r_we && !w_err) ? w_be : 4'b0000;
  assign w_ram_idx = r_addr[IDX_W+1:2];

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (ref_clk),
    .i_en    (w_ram_en),
    .i_be    (w_ram_be),
    .i_addr  (w_ram_idx),
    .i_wdata (w_wlanes),
    .o_rdata (w_ram_q)
  );

  assign w_ack     = (r_state == RESP);
  assign bus.ack   = w_ack;
  assign bus.busy  = (r_state != IDLE);
  assign bus.err   = w_ack & w_err;
  assign bus.rdata = (w_ack && !r_we && !w_err) ? w_load : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-addressed reference memory and
// a per-cycle compare process on ack/busy/err/rdata.
module tb_dmem_responder;
  import mips_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic ref_clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  dmem_responder_if #(.ADDR_W(32)) bus ();

  dmem_responder #(
    .ADDR_W   (32),
    .DEPTH    (DEPTH),
    .WAIT_MAX (7)
  ) dut (
    .ref_clk (ref_clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  initial cyc = 0;
  always @(posedge ref_clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem_m [NBYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: a flat byte memory, accesses aligned down to their size.
  function automatic void model_exec(input exp_t t, output logic e, output logic [31:0] d);
    int n;
    int base;
    n = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
    e = (t.size == 2'd3) || (t.addr >= 32'(NBYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    if (t.size != 2'd3 && (t.addr % n) != 0) e = 1'b1;
`endif
    d = 32'h0;
    if (!e) begin
      base = int'(t.addr) - (int'(t.addr) % n);
      for (int k = 0; k < n; k++) begin
        if (t.we) mem_m[base + k] = t.wdata[8*k +: 8];
        else      d[8*k +: 8]     = mem_m[base + k];
      end
    end
  endfunction

  initial begin
    logic        e_ack;
    logic        e_busy;
    logic        e_err;
    logic [31:0] e_rd;
    forever begin
      @(negedge ref_clk);
      #2;
      if (reset) begin
        e_ack  = 1'b0;
        e_busy = 1'b0;
        if (q.size() > 0) begin
          e_busy = (cyc >= q[0].acc_cyc) && (cyc <= q[0].ack_cyc);
          e_ack  = (cyc == q[0].ack_cyc);
        end
        chk("ack", 32'(bus.ack), 32'(e_ack));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        if (e_ack) begin
          model_exec(q[0], e_err, e_rd);
          chk("err", 32'(bus.err), 32'(e_err));
          chk("rdata", bus.rdata, e_rd);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] wcfg,
                        output logic [31:0] rd, output logic er, output int lat);
    exp_t t;
    bit   got;
    @(negedge ref_clk);
    bus.req      = 1'b1;
    bus.we       = we;
    bus.size     = mem_size_t'(sz);
    bus.addr     = addr;
    bus.wdata    = wdata;
    bus.wait_cfg = wcfg;
    t.we      = we;
    t.size    = sz;
    t.addr    = addr;
    t.wdata   = wdata;
    t.acc_cyc = cyc + 1;
    t.ack_cyc = cyc + 1 + int'(wcfg) + 1;
    q.push_back(t);
    got = 1'b0;
    rd  = 32'h0;
    er  = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ref_clk);
      if (bus.ack) begin
        got = 1'b1;
        rd  = bus.rdata;
        er  = bus.err;
        lat = cyc - t.acc_cyc + 1;
      end
    end
    bus.req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout addr=%h actual=no_ack expected=ack", addr);
      q.delete();
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    exp_t        t;

    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.size     = SZ_WORD;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.wait_cfg = '0;

    repeat (2) @(posedge ref_clk);
    @(negedge ref_clk);
    reset = 1'b1;
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);

    do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 3'd0, rd, er, lat);
    chk("st_w0_lat", 32'(lat), 32'd2);
    chk("st_w0_err", 32'(er), 32'h0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 3'd0, rd, er, lat);
    chk("ld_w0_lat", 32'(lat), 32'd2);
    chk("ld_w0_data", rd, 32'hDEADBEEF);

    do_req(1'b1, 2'b10, 32'h10, 32'h11223344, 3'd3, rd, er, lat);
    do_req(1'b1, 2'b00, 32'h13, 32'h000000A5, 3'd3, rd, er, lat);
    chk("st_b_lat", 32'(lat), 32'd5);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 3'd3, rd, er, lat);
    chk("ld_merge", rd, 32'hA5223344);
    chk("ld_merge_lat", 32'(lat), 32'd5);
    do_req(1'b0, 2'b01, 32'h12, 32'h0, 3'd0, rd, er, lat);
    chk("ld_half_hi", rd, 32'h0000A522);
    do_req(1'b0, 2'b00, 32'h10, 32'h0, 3'd1, rd, er, lat);
    chk("ld_byte0", rd, 32'h00000044);
    chk("ld_w1_lat", 32'(lat), 32'd3);
    do_req(1'b0, 2'b00, 32'h13, 32'h0, 3'd2, rd, er, lat);
    chk("ld_byte3", rd, 32'h000000A5);
    do_req(1'b0, 2'b01, 32'h10, 32'h0, 3'd0, rd, er, lat);
    chk("ld_half_lo", rd, 32'h00003344);

    do_req(1'b1, 2'b10, 32'h14, 32'h00000000, 3'd0, rd, er, lat);
    do_req(1'b1, 2'b01, 32'h16, 32'h1234BEEF, 3'd1, rd, er, lat);
    do_req(1'b1, 2'b00, 32'h15, 32'hFFFFFF77, 3'd0, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h14, 32'h0, 3'd0, rd, er, lat);
    chk("lanes_kept", rd, 32'hBEEF7700);

    do_req(1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, 3'd0, rd, er, lat);
    chk("rsvd_st_err", 32'(er), 32'h1);
    do_req(1'b0, 2'b11, 32'h10, 32'h0, 3'd0, rd, er, lat);
    chk("rsvd_ld_err", 32'(er), 32'h1);
    chk("rsvd_ld_data", rd, 32'h0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 3'd0, rd, er, lat);
    chk("rsvd_unchanged", rd, 32'hA5223344);

    do_req(1'b1, 2'b10, 32'h3FC, 32'hCAFEF00D, 3'd0, rd, er, lat);
    chk("top_word_err", 32'(er), 32'h0);
    do_req(1'b1, 2'b10, 32'h000, 32'h0BADC0DE, 3'd0, rd, er, lat);
    do_req(1'b1, 2'b10, 32'h400, 32'h12345678, 3'd2, rd, er, lat);
    chk("oor_st_err", 32'(er), 32'h1);
    do_req(1'b0, 2'b00, 32'h400, 32'h0, 3'd0, rd, er, lat);
    chk("oor_ld_err", 32'(er), 32'h1);
    chk("oor_ld_data", rd, 32'h0);
    do_req(1'b0, 2'b10, 32'h000, 32'h0, 3'd0, rd, er, lat);
    chk("oor_no_alias", rd, 32'h0BADC0DE);
    do_req(1'b0, 2'b10, 32'h3FC, 32'h0, 3'd7, rd, er, lat);
    chk("top_word_data", rd, 32'hCAFEF00D);
    chk("w7_lat", 32'(lat), 32'd9);

    do_req(1'b1, 2'b10, 32'h12, 32'h99887766, 3'd0, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, 3'd0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_kept", rd, 32'hA5223344);
`else
    chk("misalign_word", rd, 32'h99887766);
`endif

    // Store aborted by reset while still in its wait states.
    @(negedge ref_clk);
    bus.req      = 1'b1;
    bus.we       = 1'b1;
    bus.size     = SZ_WORD;
    bus.addr     = 32'h14;
    bus.wdata    = 32'h55555555;
    bus.wait_cfg = 3'd5;
    t.we      = 1'b1;
    t.size    = 2'b10;
    t.addr    = 32'h14;
    t.wdata   = 32'h55555555;
    t.acc_cyc = cyc + 1;
    t.ack_cyc = cyc + 7;
    q.push_back(t);
    @(negedge ref_clk);
    @(negedge ref_clk);
    reset   = 1'b0;
    bus.req = 1'b0;
    q.delete();
    @(negedge ref_clk);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_ack", 32'(bus.ack), 32'h0);
    reset = 1'b1;
    do_req(1'b0, 2'b10, 32'h14, 32'h0, 3'd0, rd, er, lat);
    chk("abort_no_write", rd, 32'hBEEF7700);

    repeat (3) @(negedge ref_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
